// File: rtl/aes_out_serializer.sv
// aes_out_serializer: buffers 128-bit AES blocks in a small FIFO and streams them MSB-first as WORD_W-bit words.
module aes_out_serializer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [0:127]      blk_in,
  input  logic              blk_in_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              fifo_full,
  output logic              overflow
);
  localparam int N  = 128 / WORD_W;
  localparam int IW = $clog2(N);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;

  logic [0:127]    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_n;
  logic [IW-1:0]   idx;
  logic            push, wr, pop, hs;

  // A full FIFO still accepts a block when the head's last word leaves in the same cycle
  always_comb begin
    word_valid = state == STREAM;
    hs         = word_valid & word_ready;
    pop        = hs & (idx == LAST);
    push       = enable & blk_in_valid;
    wr         = push & ((count != FULL) | pop);
    count_n    = count + CW'(wr) - CW'(pop);
    state_n    = count_n != '0 ? STREAM : IDLE;
    word_last  = word_valid & (idx == LAST);
    word_out   = word_valid ? mem[rd_ptr][int'(idx) * WORD_W +: WORD_W] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      idx       <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      fifo_full <= count_n == FULL;
      if (push & ~wr) overflow <= 1'b1;
      if (wr) wr_ptr <= wr_ptr == PLAST ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PLAST ? '0 : rd_ptr + PW'(1);
      if (hs) idx <= pop ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= blk_in;
  end
endmodule
